// File: rtl/mem_access_pkg.sv
// Shared definitions for the M-stage data-memory access controller:
// memory-op codes, CP0 exception codes and the FSM state encoding.
package mem_access_pkg;

   localparam logic [3:0] OP_NONE = 4'd0;
   localparam logic [3:0] OP_LB   = 4'd1;
   localparam logic [3:0] OP_LBU  = 4'd2;
   localparam logic [3:0] OP_LH   = 4'd3;
   localparam logic [3:0] OP_LHU  = 4'd4;
   localparam logic [3:0] OP_LW   = 4'd5;
   localparam logic [3:0] OP_SB   = 4'd6;
   localparam logic [3:0] OP_SH   = 4'd7;
   localparam logic [3:0] OP_SW   = 4'd8;

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_DBE  = 5'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   function automatic logic is_load(input logic [3:0] op);
      return (op >= OP_LB) && (op <= OP_LW);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op >= OP_SB) && (op <= OP_SW);
   endfunction

   function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lo);
      return (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && lo[0]) ||
             (((op == OP_LW) || (op == OP_SW)) && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/mem_access_m_lane.sv
// Combinational byte-lane logic: byte enables, store-data replication and
// sign/zero extension of the selected load lane.
module mem_lane_ext
   import mem_access_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic [3:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] ld_ext
);

   logic [1:0]  byte_lane;
   logic        half_hi;
   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   always_comb begin
      // Big-endian lane 3-a is the bitwise inverse of a; halfwords only flip the upper bit.
      byte_lane = BIG_ENDIAN ? ~addr_lo : addr_lo;
      half_hi   = BIG_ENDIAN ? ~addr_lo[1] : addr_lo[1];
      rbyte     = rdata[{byte_lane, 3'b000} +: 8];
      rhalf     = half_hi ? rdata[31:16] : rdata[15:0];

      be         = 4'b0000;
      wdata_lane = 32'h0;
      ld_ext     = 32'h0;
      case (op)
         OP_SB: begin
            be         = 4'b0001 << byte_lane;
            wdata_lane = {4{wdata[7:0]}};
         end
         OP_SH: begin
            be         = half_hi ? 4'b1100 : 4'b0011;
            wdata_lane = {2{wdata[15:0]}};
         end
         OP_SW: begin
            be         = 4'b1111;
            wdata_lane = wdata;
         end
         OP_LB: begin
            be     = 4'b1111;
            ld_ext = {{24{rbyte[7]}}, rbyte};
         end
         OP_LBU: begin
            be     = 4'b1111;
            ld_ext = {24'h0, rbyte};
         end
         OP_LH: begin
            be     = 4'b1111;
            ld_ext = {{16{rhalf[15]}}, rhalf};
         end
         OP_LHU: begin
            be     = 4'b1111;
            ld_ext = {16'h0, rhalf};
         end
         OP_LW: begin
            be     = 4'b1111;
            ld_ext = rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_m.sv
// M-stage data-memory access controller: runs one req/ack bus transaction per
// memory instruction, stalls the pipe meanwhile and reports AdEL/AdES/DBE.
module mem_access_m
   import mem_access_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter bit BIG_ENDIAN  = 1'b0,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              valid_m,
   input  logic [3:0]        mem_op,
   input  logic [ADDR_W-1:0] addr_m,
   input  logic [31:0]       wdata_m,
   input  logic              flush_m,
   input  logic              hold_m,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata,
   output logic              stall_m,
   output logic [31:0]       ld_data_m,
   output logic              done_m,
   output logic              exc_m,
   output logic [4:0]        exc_code_m,
   output logic [1:0]        state_dbg
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   // Bus handshake: bus_req rises with addr/we/be/wdata and all of them stay
   // constant until the edge at which bus_ack is sampled high; that edge
   // completes the transfer and bus_req drops on the following cycle.
   state_e            state_q, state_d;
   logic              kill_q, kill_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        op_q, op_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [3:0]        bus_be_q, bus_be_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic [31:0]       ld_data_q, ld_data_d;
   logic              done_q, done_d;
   logic              exc_q, exc_d;
   logic [4:0]        exc_code_q, exc_code_d;

   logic              mem_valid, misal, kill_now, leave_busy;
   logic [3:0]        ext_op;
   logic [1:0]        ext_lo;
   logic [3:0]        lane_be;
   logic [31:0]       lane_wdata, lane_ld;

   // While BUSY the lane logic decodes the latched op, so extension uses the launched access.
   always_comb begin
      ext_op = (state_q == ST_BUSY) ? op_q : mem_op;
      ext_lo = (state_q == ST_BUSY) ? addr_lo_q : addr_m[1:0];
   end

   mem_lane_ext #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
      .op         (ext_op),
      .addr_lo    (ext_lo),
      .wdata      (wdata_m),
      .rdata      (bus_rdata),
      .be         (lane_be),
      .wdata_lane (lane_wdata),
      .ld_ext     (lane_ld)
   );

   always_comb begin
      mem_valid  = valid_m && (is_load(mem_op) || is_store(mem_op));
      misal      = misaligned(mem_op, addr_m[1:0]);
      kill_now   = kill_q || flush_m;
      leave_busy = 1'b0;

      state_d     = state_q;
      kill_d      = kill_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      addr_lo_d   = addr_lo_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      ld_data_d   = ld_data_q;
      done_d      = 1'b0;
      exc_d       = 1'b0;
      exc_code_d  = 5'd0;

      case (state_q)
         ST_IDLE: begin
            if (mem_valid && !flush_m) begin
               if (misal) begin
                  state_d    = ST_ERR;
                  exc_d      = 1'b1;
                  exc_code_d = is_load(mem_op) ? EXC_ADEL : EXC_ADES;
               end else begin
                  state_d     = ST_BUSY;
                  kill_d      = 1'b0;
                  cnt_d       = '0;
                  op_d        = mem_op;
                  addr_lo_d   = addr_m[1:0];
                  bus_req_d   = 1'b1;
                  bus_we_d    = is_store(mem_op);
                  bus_addr_d  = {addr_m[ADDR_W-1:2], 2'b00};
                  bus_be_d    = lane_be;
                  bus_wdata_d = lane_wdata;
               end
            end
         end
         ST_BUSY: begin
            kill_d = kill_now;
            if (bus_ack) begin
               leave_busy = 1'b1;
               if (kill_now) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d   = ST_DONE;
                  done_d    = 1'b1;
                  ld_data_d = lane_ld;
               end
            end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1))) begin
               leave_busy = 1'b1;
               if (kill_now) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d    = ST_ERR;
                  exc_d      = 1'b1;
                  exc_code_d = EXC_DBE;
               end
            end else if (TIMEOUT_CYC != 0) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (hold_m && !flush_m) begin
               done_d = 1'b1;
            end else begin
               state_d   = ST_IDLE;
               ld_data_d = 32'h0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (leave_busy) begin
         bus_req_d   = 1'b0;
         bus_we_d    = 1'b0;
         bus_addr_d  = '0;
         bus_be_d    = 4'b0000;
         bus_wdata_d = 32'h0;
         kill_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         kill_q      <= 1'b0;
         cnt_q       <= '0;
         op_q        <= 4'd0;
         addr_lo_q   <= 2'd0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= 4'b0000;
         bus_wdata_q <= 32'h0;
         ld_data_q   <= 32'h0;
         done_q      <= 1'b0;
         exc_q       <= 1'b0;
         exc_code_q  <= 5'd0;
      end else begin
         state_q     <= state_d;
         kill_q      <= kill_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         addr_lo_q   <= addr_lo_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         ld_data_q   <= ld_data_d;
         done_q      <= done_d;
         exc_q       <= exc_d;
         exc_code_q  <= exc_code_d;
      end
   end

   assign stall_m    = ((state_q == ST_IDLE) && mem_valid && !misal && !flush_m) ||
                       (state_q == ST_BUSY);
   assign bus_req    = bus_req_q;
   assign bus_we     = bus_we_q;
   assign bus_addr   = bus_addr_q;
   assign bus_be     = bus_be_q;
   assign bus_wdata  = bus_wdata_q;
   assign ld_data_m  = ld_data_q;
   assign done_m     = done_q;
   assign exc_m      = exc_q;
   assign exc_code_m = exc_code_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_mem_access_m.sv
// Directed bench for mem_access_m: a little-endian and a big-endian instance
// share one stimulus stream; both use a 4-cycle bus timeout.
module tb_mem_access_m;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        valid_m = 1'b0;
   logic [3:0]  mem_op = 4'd0;
   logic [31:0] addr_m = 32'h0;
   logic [31:0] wdata_m = 32'h0;
   logic        flush_m = 1'b0;
   logic        hold_m = 1'b0;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = 32'h0;

   logic        bus_req, bus_we, stall_m, done_m, exc_m;
   logic [31:0] bus_addr, bus_wdata, ld_data_m;
   logic [3:0]  bus_be;
   logic [4:0]  exc_code_m;
   logic [1:0]  state_dbg;

   logic        b_req, b_we, b_stall, b_done, b_exc;
   logic [31:0] b_addr, b_wdata, b_ld;
   logic [3:0]  b_be;
   logic [4:0]  b_code;
   logic [1:0]  b_state;

   int total = 0;
   int bad   = 0;
   int          stalls;
   logic [31:0] cap_addr, cap_wd;
   logic [3:0]  cap_be;
   logic        cap_we;

   always #5 clk = ~clk;

   mem_access_m #(.ADDR_W(32), .BIG_ENDIAN(1'b0), .TIMEOUT_CYC(4)) dut (
      .clk(clk), .reset_n(reset_n), .valid_m(valid_m), .mem_op(mem_op),
      .addr_m(addr_m), .wdata_m(wdata_m), .flush_m(flush_m), .hold_m(hold_m),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .stall_m(stall_m), .ld_data_m(ld_data_m), .done_m(done_m), .exc_m(exc_m),
      .exc_code_m(exc_code_m), .state_dbg(state_dbg)
   );

   mem_access_m #(.ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT_CYC(4)) dut_be (
      .clk(clk), .reset_n(reset_n), .valid_m(valid_m), .mem_op(mem_op),
      .addr_m(addr_m), .wdata_m(wdata_m), .flush_m(flush_m), .hold_m(hold_m),
      .bus_req(b_req), .bus_we(b_we), .bus_addr(b_addr), .bus_be(b_be),
      .bus_wdata(b_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .stall_m(b_stall), .ld_data_m(b_ld), .done_m(b_done), .exc_m(b_exc),
      .exc_code_m(b_code), .state_dbg(b_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Drives one access with nwait ack-less BUSY cycles; returns in the DONE cycle.
   task automatic access(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int nwait,
                         output int n_stall, output logic [31:0] c_addr,
                         output logic [3:0] c_be, output logic [31:0] c_wd,
                         output logic c_we);
      n_stall   = 0;
      valid_m   = 1'b1;
      mem_op    = op;
      addr_m    = addr;
      wdata_m   = wd;
      bus_rdata = rd;
      bus_ack   = 1'b0;
      #1;
      if (stall_m) n_stall++;
      tick();
      c_addr = bus_addr;
      c_be   = bus_be;
      c_wd   = bus_wdata;
      c_we   = bus_we;
      for (int i = 0; i < nwait; i++) begin
         if (stall_m) n_stall++;
         tick();
      end
      if (stall_m) n_stall++;
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      valid_m = 1'b0;
      mem_op  = 4'd0;
   endtask

   initial begin
      // reset state
      #1;
      chk("rst_req", bus_req, 0);
      chk("rst_stall", stall_m, 0);
      chk("rst_done", done_m, 0);
      chk("rst_ld", ld_data_m, 0);
      chk("rst_exc", {exc_m, exc_code_m}, 0);
      chk("rst_state", state_dbg, 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      tick();

      // non-memory and invalid instructions
      valid_m = 1'b1; mem_op = 4'd12; addr_m = 32'h3;
      #1 chk("nonmem_stall", stall_m, 0);
      tick();
      chk("nonmem_state", state_dbg, 0);
      chk("nonmem_req", bus_req, 0);
      valid_m = 1'b0; mem_op = 4'd5; addr_m = 32'h40;
      #1 chk("invalid_stall", stall_m, 0);
      tick();
      chk("invalid_req", bus_req, 0);

      // LB 0x103 zero-wait, little-endian lane 3
      access(4'd1, 32'h103, 32'h0, 32'h80FF_1234, 0, stalls, cap_addr, cap_be, cap_wd, cap_we);
      chk("lb_stalls", stalls, 2);
      chk("lb_be", cap_be, 4'b1111);
      chk("lb_addr", cap_addr, 32'h100);
      chk("lb_we", cap_we, 0);
      chk("lb_done", done_m, 1);
      chk("lb_ld", ld_data_m, 32'hFFFF_FF80);
      chk("lb_done_stall", stall_m, 0);
      chk("lb_req_drop", bus_req, 0);
      tick();
      chk("lb_idle_done", done_m, 0);
      chk("lb_idle_state", state_dbg, 0);

      // LBU same address
      access(4'd2, 32'h103, 32'h0, 32'h80FF_1234, 0, stalls, cap_addr, cap_be, cap_wd, cap_we);
      chk("lbu_ld", ld_data_m, 32'h0000_0080);
      chk("lbu_be_ld", b_ld, 32'h0000_0034);
      tick();

      // SH 0x202 with 3 wait states
      access(4'd7, 32'h202, 32'h0000_ABCD, 32'h0, 3, stalls, cap_addr, cap_be, cap_wd, cap_we);
      chk("sh_addr", cap_addr, 32'h200);
      chk("sh_be", cap_be, 4'b1100);
      chk("sh_wdata", cap_wd, 32'hABCD_ABCD);
      chk("sh_we", cap_we, 1);
      chk("sh_stalls", stalls, 5);
      chk("sh_done", done_m, 1);
      chk("sh_be_bigend", b_be, 4'b0000);
      tick();

      // SB 0x0101: byte replicated, lane 1
      access(4'd6, 32'h101, 32'h0000_005A, 32'h0, 1, stalls, cap_addr, cap_be, cap_wd, cap_we);
      chk("sb_be", cap_be, 4'b0010);
      chk("sb_wdata", cap_wd, 32'h5A5A_5A5A);
      chk("sb_stalls", stalls, 3);
      tick();

      // misaligned LW -> AdEL, no bus access
      valid_m = 1'b1; mem_op = 4'd5; addr_m = 32'h1001;
      #1 chk("adel_stall", stall_m, 0);
      tick();
      valid_m = 1'b0; mem_op = 4'd0;
      chk("adel_exc", exc_m, 1);
      chk("adel_code", exc_code_m, 4);
      chk("adel_req", bus_req, 0);
      chk("adel_err_stall", stall_m, 0);
      tick();
      chk("adel_pulse", exc_m, 0);
      chk("adel_state", state_dbg, 0);

      // misaligned SW -> AdES
      valid_m = 1'b1; mem_op = 4'd8; addr_m = 32'h1002;
      tick();
      valid_m = 1'b0; mem_op = 4'd0;
      chk("ades_exc", exc_m, 1);
      chk("ades_code", exc_code_m, 5);
      chk("ades_req", bus_req, 0);
      tick();
      chk("ades_pulse", exc_m, 0);

      // timeout: 4 BUSY cycles without ack -> DBE
      valid_m = 1'b1; mem_op = 4'd5; addr_m = 32'h300;
      tick();
      valid_m = 1'b0; mem_op = 4'd0;
      chk("to_req_rise", bus_req, 1);
      repeat (3) tick();
      chk("to_req_held", bus_req, 1);
      chk("to_no_exc_yet", exc_m, 0);
      tick();
      chk("to_exc", exc_m, 1);
      chk("to_code", exc_code_m, 7);
      chk("to_req_drop", bus_req, 0);
      chk("to_err_stall", stall_m, 0);
      tick();
      chk("to_pulse", exc_m, 0);
      chk("to_state", state_dbg, 0);

      // flush in BUSY: bus completes, no done, no exception
      valid_m = 1'b1; mem_op = 4'd5; addr_m = 32'h400; bus_rdata = 32'h1111_1111;
      tick();
      valid_m = 1'b0; mem_op = 4'd0; flush_m = 1'b1;
      tick();
      flush_m = 1'b0;
      chk("fl_req_held1", bus_req, 1);
      tick();
      chk("fl_req_held2", bus_req, 1);
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      chk("fl_done", done_m, 0);
      chk("fl_exc", exc_m, 0);
      chk("fl_req_drop", bus_req, 0);
      chk("fl_state", state_dbg, 0);

      // flushed access that times out stays silent
      valid_m = 1'b1; mem_op = 4'd1; addr_m = 32'h500;
      tick();
      valid_m = 1'b0; mem_op = 4'd0; flush_m = 1'b1;
      tick();
      flush_m = 1'b0;
      repeat (3) tick();
      chk("flto_exc", exc_m, 0);
      chk("flto_state", state_dbg, 0);
      chk("flto_req", bus_req, 0);

      // flush in IDLE suppresses launch
      valid_m = 1'b1; mem_op = 4'd5; addr_m = 32'h600; flush_m = 1'b1;
      #1 chk("flidle_stall", stall_m, 0);
      tick();
      valid_m = 1'b0; mem_op = 4'd0; flush_m = 1'b0;
      chk("flidle_req", bus_req, 0);

      // asynchronous reset mid-BUSY
      valid_m = 1'b1; mem_op = 4'd8; addr_m = 32'h700; wdata_m = 32'hDEAD_BEEF;
      tick();
      valid_m = 1'b0; mem_op = 4'd0;
      chk("ar_req_rise", bus_req, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_req", bus_req, 0);
      chk("ar_bus", {bus_we, bus_be, bus_wdata[26:0]}, 0);
      chk("ar_addr", bus_addr, 0);
      chk("ar_stall", stall_m, 0);
      chk("ar_state", state_dbg, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      tick();

      // LH 0x0 with hold: big-endian picks upper half, little-endian lower
      hold_m = 1'b1;
      access(4'd3, 32'h0, 32'h0, 32'h1234_8000, 0, stalls, cap_addr, cap_be, cap_wd, cap_we);
      for (int i = 0; i < 3; i++) begin
         chk("lh_be_done", b_done, 1);
         chk("lh_be_ld", b_ld, 32'h0000_1234);
         chk("lh_le_ld", ld_data_m, 32'hFFFF_8000);
         chk("lh_hold_stall", stall_m, 0);
         tick();
      end
      hold_m = 1'b0;
      chk("lh_still_done", done_m, 1);
      tick();
      chk("lh_release", done_m, 0);
      chk("lh_be_release", b_done, 0);
      chk("lh_ld_clr", ld_data_m, 0);

      // LHU at 0x2 little-endian upper half
      access(4'd4, 32'h2, 32'h0, 32'h8765_4321, 0, stalls, cap_addr, cap_be, cap_wd, cap_we);
      chk("lhu_ld", ld_data_m, 32'h0000_8765);
      chk("lhu_be_ld", b_ld, 32'h0000_4321);
      tick();

      // flush in DONE returns to IDLE despite hold
      hold_m = 1'b1;
      access(4'd5, 32'h10, 32'h0, 32'hCAFE_F00D, 0, stalls, cap_addr, cap_be, cap_wd, cap_we);
      chk("lw_ld", ld_data_m, 32'hCAFE_F00D);
      flush_m = 1'b1;
      tick();
      flush_m = 1'b0; hold_m = 1'b0;
      chk("done_flush", done_m, 0);
      chk("done_flush_state", state_dbg, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
